// File: rtl/gb_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gb_uart_pkg : 8N1 frame constants and baud divisor helper for board UARTs   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package gb_uart_pkg;
  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  function automatic int baud_div(input int f_clk, input int baud);
    return f_clk / baud;
  endfunction
endpackage
`default_nettype wire

// File: rtl/prog_dumper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_dumper_pkg : bus width and FSM state encoding of the memory dumper    |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
package prog_dumper_pkg;
  localparam int ADR_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ     = 2'd1,
    ST_WAIT_CTS = 2'd2,
    ST_SEND     = 2'd3
  } state_e;
endpackage
`default_nettype wire

// File: rtl/prog_dumper_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_dumper_if : host control, memory read bus and UART pins of the dumper |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
interface prog_dumper_if;
  import prog_dumper_pkg::*;

  logic             start;
  logic [ADR_W-1:0] start_adr;
  logic [ADR_W-1:0] length;
  logic [ADR_W-1:0] adr;
  logic             read;
  logic [7:0]       din;
  logic             cts;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    input  start, start_adr, length, din, cts,
    output adr, read, tx, busy, done
  );

  modport slave (
    output start, start_adr, length, din, cts,
    input  adr, read, tx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_byte : single-byte 8N1 transmitter, LSB first, CLK_DIV clocks/bit  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_tx_byte
  import gb_uart_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 tx
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic                           active_q;
  logic [DIV_W-1:0]               div_q;
  logic [BIT_W-1:0]               bit_q;
  logic [DATA_BITS+STOP_BITS-1:0] shift_q;
  logic                           tx_q;
  logic                           w_tick;
  logic                           w_last;

  assign w_tick = active_q && (div_q == DIV_LAST);
  assign w_last = w_tick && (bit_q == BIT_LAST);
  // ready covers the final stop-bit cycle so a back-to-back byte can load on that edge
  assign ready  = !active_q || w_last;
  assign tx     = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= IDLE_LEVEL;
    end else if (valid && ready) begin
      active_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= {{STOP_BITS{IDLE_LEVEL}}, data};
      tx_q     <= ~IDLE_LEVEL;
    end else if (w_last) begin
      active_q <= 1'b0;
      div_q    <= '0;
    end else if (w_tick) begin
      div_q    <= '0;
      bit_q    <= bit_q + 1'b1;
      tx_q     <= shift_q[0];
      shift_q  <= {IDLE_LEVEL, shift_q[DATA_BITS+STOP_BITS-1:1]};
    end else if (active_q) begin
      div_q    <= div_q + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/prog_dumper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_dumper : reads a memory range byte by byte and streams it out on UART |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module prog_dumper
  import prog_dumper_pkg::*;
#(
  parameter int CLK_DIV   = 104,
  parameter int READ_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  prog_dumper_if.master bus
);
  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [ADR_W-1:0] rem_q, rem_d;
  logic [ADR_W-1:0] w_rem_dec;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]       byte_q, byte_d;
  logic             read_q, read_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cts_meta_q, cts_s_q;
  logic             w_tx_valid;
  logic             w_tx_ready;
  logic             w_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
    end else begin
      cts_meta_q <= bus.cts;
      cts_s_q    <= cts_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      byte_q  <= '0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      byte_q  <= byte_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    wait_d     = wait_q;
    byte_d     = byte_q;
    read_d     = read_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    w_tx_valid = 1'b0;
    w_rem_dec  = rem_q - 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            adr_d   = bus.start_adr;
            rem_d   = bus.length;
            wait_d  = '0;
            read_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_READ;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (wait_q == WAIT_LAST) begin
          byte_d  = bus.din;
          read_d  = 1'b0;
          state_d = ST_WAIT_CTS;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end
      ST_WAIT_CTS: begin
        if (cts_s_q) begin
          w_tx_valid = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // The stop-bit edge does the next-byte bookkeeping itself, keeping the gap at READ_WAIT+1
        if (w_tx_ready) begin
          rem_d = w_rem_dec;
          if (w_rem_dec != '0) begin
            adr_d   = adr_q + 1'b1;
            wait_d  = '0;
            read_d  = 1'b1;
            state_d = ST_READ;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .valid (w_tx_valid),
    .data  (byte_q),
    .ready (w_tx_ready),
    .tx    (w_tx)
  );

  assign bus.adr  = adr_q;
  assign bus.read = read_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tx   = w_tx;
endmodule
`default_nettype wire
